// File: rtl/mac_sequencer_if.sv
// Memory and MAC datapath bus of the matrix-multiply sequencer.
// The master side is the sequencer; the slave side is the A/B/C memories plus the MAC unit.
interface mac_sequencer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ACC_W  = 16
) ();
    logic [ADDR_W-1:0] a_addr;
    logic              a_re;
    logic [7:0]        a_rdata;
    logic [ADDR_W-1:0] b_addr;
    logic              b_re;
    logic [7:0]        b_rdata;
    logic [7:0]        mplier;
    logic [7:0]        mcand;
    logic              mac_clr;
    logic              mac_en;
    logic [ACC_W-1:0]  mac_dout;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;
    logic [ACC_W-1:0]  c_wdata;

    modport master (
        output a_addr, a_re, b_addr, b_re,
        input  a_rdata, b_rdata,
        output mplier, mcand, mac_clr, mac_en,
        input  mac_dout,
        output c_addr, c_we, c_wdata
    );

    modport slave (
        input  a_addr, a_re, b_addr, b_re,
        output a_rdata, b_rdata,
        input  mplier, mcand, mac_clr, mac_en,
        output mac_dout,
        input  c_addr, c_we, c_wdata
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences one shared 8x8 MAC to compute C = A x B for NxN unsigned 8-bit matrices.
// Per element: CLR, N RUN reads, DRAIN for the last product, WB of the dot product.
module mac_sequencer #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned ACC_W  = 16
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            start,
    output logic            busy,
    output logic            done,
    mac_sequencer_if.master bus
);
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StWb, StDone} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  i_q, j_q, k_q;
    logic              rd_valid_q;
    logic              busy_q, done_q, a_re_q, b_re_q, mac_clr_q, c_we_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q, c_addr_q;

    function automatic logic [ADDR_W-1:0] lin(input logic [IDX_W-1:0] r,
                                              input logic [IDX_W-1:0] c);
        return ADDR_W'(32'(r) * N + 32'(c));
    endfunction

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q    <= StIdle;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a_re_q     <= 1'b0;
            b_re_q     <= 1'b0;
            mac_clr_q  <= 1'b0;
            c_we_q     <= 1'b0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_addr_q   <= '0;
        end else begin
            rd_valid_q <= a_re_q;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StClr;
                        i_q       <= '0;
                        j_q       <= '0;
                        busy_q    <= 1'b1;
                        mac_clr_q <= 1'b1;
                    end
                end
                StClr: begin
                    mac_clr_q <= 1'b0;
                    k_q       <= '0;
                    a_re_q    <= 1'b1;
                    b_re_q    <= 1'b1;
                    a_addr_q  <= lin(i_q, '0);
                    b_addr_q  <= lin('0, j_q);
                    state_q   <= StRun;
                end
                StRun: begin
                    // k_q is the index whose reads are on the bus this cycle
                    if (k_q == LAST) begin
                        a_re_q  <= 1'b0;
                        b_re_q  <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        k_q      <= k_q + 1'b1;
                        a_addr_q <= lin(i_q, k_q + 1'b1);
                        b_addr_q <= lin(k_q + 1'b1, j_q);
                    end
                end
                StDrain: begin
                    c_we_q   <= 1'b1;
                    c_addr_q <= lin(i_q, j_q);
                    state_q  <= StWb;
                end
                StWb: begin
                    c_we_q <= 1'b0;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (i_q == LAST && j_q == LAST) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= StClr;
                        mac_clr_q <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign bus.a_re    = a_re_q;
    assign bus.b_re    = b_re_q;
    assign bus.a_addr  = a_addr_q;
    assign bus.b_addr  = b_addr_q;
    assign bus.mac_clr = mac_clr_q;
    assign bus.mac_en  = rd_valid_q;
    assign bus.mplier  = rd_valid_q ? bus.a_rdata : 8'd0;
    assign bus.mcand   = rd_valid_q ? bus.b_rdata : 8'd0;
    assign bus.c_we    = c_we_q;
    assign bus.c_addr  = c_addr_q;
    // MAC output settles at the end of DRAIN, so the write data is taken live in WB
    assign bus.c_wdata = c_we_q ? bus.mac_dout : '0;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: N=4 and N=2 instances with memory and MAC models.
module tb_mac_sequencer;
    logic clk;
    logic aclr;
    logic start4, busy4, done4;
    logic start2, busy2, done2;

    mac_sequencer_if #(.ADDR_W(4), .ACC_W(16)) bus4 ();
    mac_sequencer_if #(.ADDR_W(2), .ACC_W(16)) bus2 ();

    mac_sequencer #(.N(4), .ADDR_W(4), .ACC_W(16)) dut4 (
        .clk(clk), .aclr(aclr), .start(start4), .busy(busy4), .done(done4), .bus(bus4.master)
    );
    mac_sequencer #(.N(2), .ADDR_W(2), .ACC_W(16)) dut2 (
        .clk(clk), .aclr(aclr), .start(start2), .busy(busy2), .done(done2), .bus(bus2.master)
    );

    logic [7:0]  a4 [16];
    logic [7:0]  b4 [16];
    logic [15:0] exp4 [16];
    logic [7:0]  a2 [4];
    logic [7:0]  b2 [4];

    int checks = 0;
    int errors = 0;
    int wc4 = 0, dc4 = 0, wc2 = 0;
    int          log4_addr [256];
    logic [15:0] log4_data [256];
    int          log2_addr [256];
    logic [15:0] log2_data [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories and MAC units
    always_ff @(posedge clk) begin
        if (bus4.a_re) bus4.a_rdata <= a4[bus4.a_addr];
        if (bus4.b_re) bus4.b_rdata <= b4[bus4.b_addr];
        if (bus2.a_re) bus2.a_rdata <= a2[bus2.a_addr];
        if (bus2.b_re) bus2.b_rdata <= b2[bus2.b_addr];
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            bus4.mac_dout <= '0;
            bus2.mac_dout <= '0;
        end else begin
            if (bus4.mac_clr) bus4.mac_dout <= '0;
            else if (bus4.mac_en)
                bus4.mac_dout <= bus4.mac_dout + 16'(bus4.mplier) * 16'(bus4.mcand);
            if (bus2.mac_clr) bus2.mac_dout <= '0;
            else if (bus2.mac_en)
                bus2.mac_dout <= bus2.mac_dout + 16'(bus2.mplier) * 16'(bus2.mcand);
        end
    end

    always @(negedge clk) begin
        if (bus4.c_we === 1'b1) begin
            log4_addr[wc4] = int'(bus4.c_addr);
            log4_data[wc4] = bus4.c_wdata;
            if (wc4 < 255) wc4++;
        end
        if (done4 === 1'b1) dc4++;
        if (bus2.c_we === 1'b1) begin
            log2_addr[wc2] = int'(bus2.c_addr);
            log2_data[wc2] = bus2.c_wdata;
            if (wc2 < 255) wc2++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] outs4();
        return 64'({busy4, done4, bus4.a_re, bus4.b_re, bus4.mac_clr, bus4.mac_en, bus4.c_we,
                    bus4.a_addr, bus4.b_addr, bus4.mplier, bus4.mcand, bus4.c_addr,
                    bus4.c_wdata});
    endfunction

    function automatic logic [63:0] outs2();
        return 64'({busy2, done2, bus2.a_re, bus2.b_re, bus2.mac_clr, bus2.mac_en, bus2.c_we,
                    bus2.a_addr, bus2.b_addr, bus2.mplier, bus2.mcand, bus2.c_addr,
                    bus2.c_wdata});
    endfunction

    // Called at a negedge while the N=4 DUT is idle; returns at the negedge after done.
    task automatic run4(input string name, input bit glitch);
        int t, bc, base, dbase;
        base   = wc4;
        dbase  = dc4;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        t = 1;
        check({name, "_clr_first"}, 64'(bus4.mac_clr), 64'd1);
        bc = 0;
        while (done4 !== 1'b1 && t < 400) begin
            if (busy4 === 1'b1) bc++;
            @(negedge clk);
            t++;
            start4 = glitch && (t == 5 || t == 60);
        end
        start4 = 1'b0;
        check({name, "_cycles"}, 64'(t), 64'd113);
        check({name, "_busy_cycles"}, 64'(bc), 64'd112);
        check({name, "_busy_at_done"}, 64'(busy4), 64'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done4), 64'd0);
        check({name, "_writes"}, 64'(wc4 - base), 64'd16);
        check({name, "_dones"}, 64'(dc4 - dbase), 64'd1);
        for (int m = 0; m < 16; m++) begin
            check($sformatf("%s_addr%0d", name, m), 64'(log4_addr[base + m]), 64'(m));
            check($sformatf("%s_data%0d", name, m), 64'(log4_data[base + m]), 64'(exp4[m]));
        end
    endtask

    initial begin
        int t, base, dbase;
        aclr   = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        #12;
        check("reset_outs4", outs4(), 64'd0);
        check("reset_outs2", outs2(), 64'd0);
        @(negedge clk);
        aclr = 1'b1;
        @(negedge clk);
        check("idle_outs4", outs4(), 64'd0);

        // Identity times B: C[m] = m+1
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a4[i*4+k]   = (i == k) ? 8'd1 : 8'd0;
                b4[i*4+k]   = 8'(i*4 + k + 1);
                exp4[i*4+k] = 16'(i*4 + k + 1);
            end
        run4("ident", 1'b0);

        // All 0xFF wraps to 0xF804
        for (int m = 0; m < 16; m++) begin
            a4[m]   = 8'hFF;
            b4[m]   = 8'hFF;
            exp4[m] = 16'hF804;
        end
        run4("allff", 1'b0);

        // Row-scaled A with constant B: rows 8, 16, 24, 32
        for (int m = 0; m < 16; m++) begin
            a4[m]   = 8'(m / 4 + 1);
            b4[m]   = 8'd2;
            exp4[m] = 16'(8 * (m / 4 + 1));
        end
        run4("rows", 1'b0);
        run4("glitch", 1'b1);
        run4("backtoback", 1'b0);

        // Abort in RUN of element 6 (cycles 44..47 after start)
        base   = wc4;
        dbase  = dc4;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        t = 1;
        while (t < 45) begin
            @(negedge clk);
            t++;
        end
        check("abort_in_run", 64'(bus4.a_re), 64'd1);
        aclr = 1'b0;
        #1;
        check("abort_outs4", outs4(), 64'd0);
        check("abort_writes", 64'(wc4 - base), 64'd6);
        repeat (5) @(negedge clk);
        check("abort_writes_held", 64'(wc4 - base), 64'd6);
        check("abort_no_done", 64'(dc4 - dbase), 64'd0);
        aclr = 1'b1;
        @(negedge clk);
        check("abort_idle", outs4(), 64'd0);
        run4("after_abort", 1'b0);

        // N=2 instance: [[1,2],[3,4]] x [[5,6],[7,8]]
        a2[0] = 8'd1; a2[1] = 8'd2; a2[2] = 8'd3; a2[3] = 8'd4;
        b2[0] = 8'd5; b2[1] = 8'd6; b2[2] = 8'd7; b2[3] = 8'd8;
        base   = wc2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t = 1;
        while (done2 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("n2_cycles", 64'(t), 64'd21);
        @(negedge clk);
        check("n2_done_pulse", 64'(done2), 64'd0);
        check("n2_writes", 64'(wc2 - base), 64'd4);
        check("n2_c0", 64'(log2_data[base]), 64'd19);
        check("n2_c1", 64'(log2_data[base + 1]), 64'd22);
        check("n2_c2", 64'(log2_data[base + 2]), 64'd43);
        check("n2_c3", 64'(log2_data[base + 3]), 64'd50);
        for (int m = 0; m < 4; m++)
            check($sformatf("n2_addr%0d", m), 64'(log2_addr[base + m]), 64'(m));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that sequences one shared 8x8 multiply-accumulate unit to compute C = A x B for NxN matrices of unsigned 8-bit elements.
- Reads A and B from two synchronous-read element memories and drives the MAC operand, clear and enable lines.
- Writes each 16-bit dot product to the C result memory, then signals done; it sits between the matrix memories and the MAC datapath.

Parameters:
N, 4, matrix dimension (2..15)
ADDR_W, 4, element address width; must satisfy 2^ADDR_W >= N*N
ACC_W, 16, accumulator/result width

Ports:
clk  in  1  system clock, rising edge
aclr  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a full matrix multiply
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last C write
a_addr  out  ADDR_W  A read address (row-major, i*N+k)
a_re  out  1  A read enable
a_rdata  in  8  A read data, valid 1 cycle after a_re
b_addr  out  ADDR_W  B read address (row-major, k*N+j)
b_re  out  1  B read enable
b_rdata  in  8  B read data, valid 1 cycle after b_re
mplier  out  8  MAC multiplier operand
mcand  out  8  MAC multiplicand operand
mac_clr  out  1  synchronous accumulator clear to MAC
mac_en  out  1  MAC accumulate enable
mac_dout  in  ACC_W  MAC accumulator value (registered in MAC)
c_addr  out  ADDR_W  C write address (i*N+j)
c_we  out  1  C write enable
c_wdata  out  ACC_W  C write data

Behaviour:
- MAC contract: on posedge clk, mac_clr -> acc=0; else mac_en -> acc = acc + mplier*mcand, modulo 2^ACC_W; mac_dout = acc.
- Reset (aclr=0, asynchronous): state=IDLE; i, j and k = 0; rd_valid=0. All outputs are 0: busy, done, a_re, b_re, mac_clr, mac_en, c_we, all addresses, mplier, mcand, c_wdata.
- States: IDLE, CLR, RUN, DRAIN, WB, DONE.
- IDLE: start=1 -> CLR with i=j=0. start is ignored in every other state.
- CLR (1 cycle): mac_clr=1, k=0 -> RUN.
- RUN (N cycles): a_re=b_re=1, a_addr=i*N+k, b_addr=k*N+j, k++. When k==N-1 -> DRAIN.
- rd_valid is a register equal to a_re delayed one cycle; mac_en = rd_valid.
- Operands: mplier = rd_valid ? a_rdata : 0; mcand = rd_valid ? b_rdata : 0 (combinational).
- DRAIN (1 cycle): no reads issued; the final product is accumulated via rd_valid -> WB.
- WB (1 cycle): c_we=1, c_addr=i*N+j, c_wdata=mac_dout, which now holds the full dot product.
  - Then j++; if j wraps then j=0 and i++.
  - After element (N-1,N-1) -> DONE, else -> CLR.
- DONE: done=1 for one cycle, busy=0 -> IDLE. A start in the DONE cycle is ignored; a new start is accepted from IDLE the next cycle.
- busy = 1 in CLR, RUN, DRAIN and WB.
- Timing:
  - Per element: N+3 cycles.
  - First mac_clr in the cycle after start.
  - Total start-to-done is N*N*(N+3)+1 cycles; for N=4 this is 113.
- Outputs not named active in a state are 0. Addresses hold their last value when not enabled; their value outside RUN/WB is don't-care except after reset, when they are 0.
- Overflow: sums wrap modulo 2^ACC_W with no saturation and no flag.
- C elements are written in row-major order, exactly once each per run.
- Reset mid-operation: immediate abort, no further C writes, and no done pulse. A partially written C is left as is.

Test Plan:
- N=4, A=identity, B[k][j]=4k+j+1 -> 16 writes, c_wdata at c_addr m equals m+1, in order 0..15; done 113 cycles after start; busy high for 112 cycles.
- N=4, A=B=all 0xFF -> every c_wdata = (4*65025) mod 65536 = 0xF804.
- N=4, A[i][k]=i+1, B=all 2 -> rows of C are 8, 16, 24, 32; checks i/j/k indexing and the mac_clr between elements (no carry-over).
- start pulsed again at cycles 5 and 60 of a run -> ignored, still exactly 16 writes and one done; start in the cycle after done -> second full run with identical results.
- aclr dropped during RUN of element 6 -> all outputs 0 immediately, no c_we or done; after release and start, a complete correct run follows.
- N=2 build, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C writes 19, 22, 43, 50; done 21 cycles after start.
